// File: rtl/fft_bit_reverse_if.sv
// Sample stream bundle for the FFT output reorder buffer: bit-reversed samples in,
// natural-order bins out.
interface fft_bit_reverse_if #(
  parameter int unsigned DATA_WIDTH = 25,
  parameter int unsigned N_LOG2     = 10
) ();
  logic                  valid_i;
  logic                  start_i;
  logic [DATA_WIDTH-1:0] x_re_i;
  logic [DATA_WIDTH-1:0] x_im_i;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] z_re_o;
  logic [DATA_WIDTH-1:0] z_im_o;
  logic [N_LOG2-1:0]     index_o;
  logic                  last_o;
  logic                  frame_err_o;

  modport slave (
    input  valid_i, start_i, x_re_i, x_im_i,
    output valid_o, z_re_o, z_im_o, index_o, last_o, frame_err_o
  );

  modport master (
    output valid_i, start_i, x_re_i, x_im_i,
    input  valid_o, z_re_o, z_im_o, index_o, last_o, frame_err_o
  );
endinterface

// File: rtl/fft_bit_reverse.sv
// FFT output reorder: writes each frame into a ping-pong RAM at bit-reversed
// addresses and streams it out in natural bin order, one bin per clock.
module fft_bit_reverse #(
  parameter int unsigned DATA_WIDTH = 25,
  parameter int unsigned N_LOG2     = 10
) (
  input  logic             clk_i,
  input  logic             rst_n,
  fft_bit_reverse_if.slave bus
);
  localparam int unsigned N = 2 ** N_LOG2;

  typedef enum logic {IDLE, READ} rd_state_e;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_LOG2; i++) r[i] = a[N_LOG2-1-i];
    return r;
  endfunction

  // Writer
  logic [N_LOG2-1:0] wcnt_q;
  logic              wb_q;
  logic              armed_q;
  logic              frame_err_q;
  logic              accept;
  logic              launch;
  logic [N_LOG2-1:0] wpos;
  logic [N_LOG2-1:0] waddr;

  // start_i forces position 0, so a launch can only come from a natural wrap
  always_comb begin
    accept = bus.valid_i && (armed_q || bus.start_i);
    wpos   = bus.start_i ? '0 : wcnt_q;
    launch = accept && (wpos == '1);
    waddr  = bitrev(wpos);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wcnt_q      <= '0;
      wb_q        <= 1'b0;
      armed_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (accept) begin
      armed_q <= 1'b1;
      if (bus.start_i && (wcnt_q != '0)) frame_err_q <= 1'b1;
      wcnt_q <= wpos + N_LOG2'(1);
      if (launch) wb_q <= ~wb_q;
    end
  end

  // Reader FSM
  rd_state_e         state_q, state_d;
  logic [N_LOG2-1:0] rcnt_q, rcnt_d;
  logic              rb_q, rb_d;
  logic              rd_en;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      rb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rb_q    <= rb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rb_d    = rb_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = READ;
          rcnt_d  = '0;
          rb_d    = wb_q;
        end
      end
      READ: begin
        rd_en  = 1'b1;
        rcnt_d = rcnt_q + N_LOG2'(1);
        if (launch) begin
          rcnt_d = '0;
          rb_d   = wb_q;
        end else if (rcnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ping-pong storage, bank select in the address MSB; read-first on collision
  logic [2*DATA_WIDTH-1:0] mem [2*N];
  logic [2*DATA_WIDTH-1:0] ram_q;

  always_ff @(posedge clk_i) begin
    if (accept) mem[{wb_q, waddr}] <= {bus.x_re_i, bus.x_im_i};
    if (rd_en)  ram_q <= mem[{rb_q, rcnt_q}];
  end

  // Output pipeline
  logic                  rd_vld_q;
  logic [N_LOG2-1:0]     rd_idx_q;
  logic                  valid_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] re_q;
  logic [DATA_WIDTH-1:0] im_q;
  logic [N_LOG2-1:0]     idx_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      idx_q    <= '0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_en) rd_idx_q <= rcnt_q;
      valid_q <= rd_vld_q;
      last_q  <= rd_vld_q && (rd_idx_q == '1);
      if (rd_vld_q) begin
        re_q  <= ram_q[2*DATA_WIDTH-1:DATA_WIDTH];
        im_q  <= ram_q[DATA_WIDTH-1:0];
        idx_q <= rd_idx_q;
      end
    end
  end

  assign bus.valid_o     = valid_q;
  assign bus.last_o      = last_q;
  assign bus.z_re_o      = re_q;
  assign bus.z_im_o      = im_q;
  assign bus.index_o     = idx_q;
  assign bus.frame_err_o = frame_err_q;
endmodule

// File: tb/tb_fft_bit_reverse.sv
// Bench for fft_bit_reverse: an 8-point instance for the directed scenarios and a
// 1024-point instance for bit-exact random frames, both against a bit-reverse model.
module tb_fft_bit_reverse;
  localparam int unsigned DW = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3, rst10;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  fft_bit_reverse_if #(.DATA_WIDTH(DW), .N_LOG2(3))  if3  ();
  fft_bit_reverse_if #(.DATA_WIDTH(DW), .N_LOG2(10)) if10 ();

  fft_bit_reverse #(.DATA_WIDTH(DW), .N_LOG2(3))  dut3  (.clk_i(clk), .rst_n(rst3),  .bus(if3));
  fft_bit_reverse #(.DATA_WIDTH(DW), .N_LOG2(10)) dut10 (.clk_i(clk), .rst_n(rst10), .bus(if10));

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [9:0]    idx;
    logic          last;
    logic [31:0]   cyc;
  } smp_t;

  smp_t mon3_q[$], mon10_q[$], exp3_q[$], exp10_q[$];
  logic [2*DW-1:0] fbuf [2][1024];
  int unsigned fcnt [2];
  bit armed [2];
  bit err_exp [2];
  int stray3 = 0;

  int lit_re [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  // Output monitor: records every valid bin with the cycle it appeared
  always @(negedge clk) begin : monitor
    smp_t m;
    if (if3.valid_o) begin
      m.re = if3.z_re_o; m.im = if3.z_im_o; m.idx = 10'(if3.index_o);
      m.last = if3.last_o; m.cyc = cyc;
      mon3_q.push_back(m);
    end
    if (!if3.valid_o && if3.last_o) stray3++;
    if (if10.valid_o) begin
      m.re = if10.z_re_o; m.im = if10.z_im_o; m.idx = if10.index_o;
      m.last = if10.last_o; m.cyc = cyc;
      mon10_q.push_back(m);
    end
  end

  function automatic int unsigned rev(input int unsigned j, input int unsigned bits);
    int unsigned r = 0;
    for (int unsigned i = 0; i < bits; i++) r = r * 2 + ((j >> i) & 1);
    return r;
  endfunction

  function automatic logic [DW-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return 25'h1000000;
      1:       return 25'h0FFFFFF;
      default: return DW'($urandom);
    endcase
  endfunction

  // Drive one cycle of input and advance the reference model
  task automatic drive(input bit d, input bit v, input bit s,
                       input logic [DW-1:0] re, input logic [DW-1:0] im);
    int unsigned t, bits, n;
    smp_t e;
    @(negedge clk);
    t = cyc + 1;
    bits = d ? 10 : 3;
    n = 1 << bits;
    if (!d) begin
      if3.valid_i = v; if3.start_i = s; if3.x_re_i = re; if3.x_im_i = im;
    end else begin
      if10.valid_i = v; if10.start_i = s; if10.x_re_i = re; if10.x_im_i = im;
    end
    if (v && (armed[d] || s)) begin
      if (s) begin
        if (fcnt[d] != 0) err_exp[d] = 1'b1;
        fcnt[d] = 0;
        armed[d] = 1'b1;
      end
      fbuf[d][fcnt[d]] = {re, im};
      fcnt[d]++;
      if (fcnt[d] == n) begin
        for (int unsigned j = 0; j < n; j++) begin
          e.re   = fbuf[d][rev(j, bits)][2*DW-1:DW];
          e.im   = fbuf[d][rev(j, bits)][DW-1:0];
          e.idx  = 10'(j);
          e.last = (j == n - 1);
          e.cyc  = t + 2 + j;
          if (!d) exp3_q.push_back(e); else exp10_q.push_back(e);
        end
        fcnt[d] = 0;
      end
    end
  endtask

  task automatic idle(input bit d, input int n);
    repeat (n) drive(d, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic model_reset(input bit d);
    fcnt[d] = 0; armed[d] = 1'b0; err_exp[d] = 1'b0;
    if (!d) begin mon3_q.delete(); exp3_q.delete(); end
    else begin mon10_q.delete(); exp10_q.delete(); end
  endtask

  task automatic send_ramp(input int base_re, input int base_im, input bit first_start, input bit gap);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, first_start && (i == 0), DW'(base_re + i), DW'(base_im + i));
      if (gap) idle(1'b0, 1);
    end
  endtask

  task automatic test_reset();
    rst3 = 1'b0; rst10 = 1'b0;
    if3.valid_i = 0; if3.start_i = 0; if3.x_re_i = '0; if3.x_im_i = '0;
    if10.valid_i = 0; if10.start_i = 0; if10.x_re_i = '0; if10.x_im_i = '0;
    repeat (3) @(negedge clk);
    rst3 = 1'b1; rst10 = 1'b1;
    model_reset(1'b0); model_reset(1'b1);
    tests++;
    if ({if3.valid_o, if3.last_o, if3.frame_err_o} !== 3'b000) begin
      fails++; $display("FAIL reset_flags3 got %b exp 000", {if3.valid_o, if3.last_o, if3.frame_err_o});
    end
    tests++;
    if ({if3.z_re_o, if3.z_im_o, if3.index_o} !== '0) begin
      fails++; $display("FAIL reset_data3 got %h/%h/%0d exp 0", if3.z_re_o, if3.z_im_o, if3.index_o);
    end
    tests++;
    if ({if10.valid_o, if10.last_o, if10.frame_err_o} !== 3'b000) begin
      fails++; $display("FAIL reset_flags10 got %b exp 000", {if10.valid_o, if10.last_o, if10.frame_err_o});
    end
    tests++;
    if ({if10.z_re_o, if10.z_im_o, if10.index_o} !== '0) begin
      fails++; $display("FAIL reset_data10 got %h/%h/%0d exp 0", if10.z_re_o, if10.z_im_o, if10.index_o);
    end
  endtask

  task automatic test_prestart();
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 1'b0, pick(), pick());
    idle(1'b0, 12);
    tests++;
    if (mon3_q.size() !== 0) begin
      fails++; $display("FAIL prestart_discard got %0d outputs exp 0", mon3_q.size());
    end
    mon3_q.delete(); exp3_q.delete();
  endtask

  task automatic test_basic();
    send_ramp(0, 10, 1'b1, 1'b0);
    idle(1'b0, 12);
    tests++;
    if (mon3_q.size() !== exp3_q.size()) begin
      fails++; $display("FAIL basic_count got %0d exp %0d", mon3_q.size(), exp3_q.size());
    end
    for (int i = 0; i < exp3_q.size() && i < mon3_q.size(); i++) begin
      tests++;
      if (mon3_q[i] !== exp3_q[i]) begin
        fails++; $display("FAIL basic[%0d] got %h exp %h", i, mon3_q[i], exp3_q[i]);
      end
    end
    for (int j = 0; j < 8; j++) begin
      tests++;
      if ((j < mon3_q.size() ? mon3_q[j].re : 'x) !== DW'(lit_re[j])) begin
        fails++; $display("FAIL basic_re[%0d] got %0d exp %0d", j, j < mon3_q.size() ? mon3_q[j].re : 'x, lit_re[j]);
      end
    end
    tests++;
    if (if3.frame_err_o !== err_exp[0]) begin
      fails++; $display("FAIL basic_err got %b exp %b", if3.frame_err_o, err_exp[0]);
    end
    mon3_q.delete(); exp3_q.delete();
  endtask

  task automatic test_back_to_back();
    send_ramp(0, 100, 1'b0, 1'b0);
    send_ramp(8, 108, 1'b0, 1'b0);
    send_ramp(16, 116, 1'b0, 1'b0);
    idle(1'b0, 12);
    tests++;
    if (mon3_q.size() !== exp3_q.size() || exp3_q.size() != 24) begin
      fails++; $display("FAIL b2b_count got %0d exp 24", mon3_q.size());
    end
    for (int i = 0; i < exp3_q.size() && i < mon3_q.size(); i++) begin
      tests++;
      if (mon3_q[i] !== exp3_q[i]) begin
        fails++; $display("FAIL b2b[%0d] got %h exp %h", i, mon3_q[i], exp3_q[i]);
      end
    end
    for (int j = 0; j < 8; j++) begin
      tests++;
      if ((j + 8 < mon3_q.size() ? mon3_q[j+8].re : 'x) !== DW'(8 + lit_re[j])) begin
        fails++; $display("FAIL b2b_frame2_re[%0d] got %0d exp %0d", j, j + 8 < mon3_q.size() ? mon3_q[j+8].re : 'x, 8 + lit_re[j]);
      end
    end
    tests++;
    if (stray3 !== 0) begin
      fails++; $display("FAIL stray_last got %0d exp 0", stray3);
    end
    mon3_q.delete(); exp3_q.delete();
  endtask

  task automatic test_gapped();
    send_ramp(0, 10, 1'b0, 1'b1);
    idle(1'b0, 12);
    tests++;
    if (mon3_q.size() !== exp3_q.size()) begin
      fails++; $display("FAIL gapped_count got %0d exp %0d", mon3_q.size(), exp3_q.size());
    end
    for (int i = 0; i < exp3_q.size() && i < mon3_q.size(); i++) begin
      tests++;
      if (mon3_q[i] !== exp3_q[i]) begin
        fails++; $display("FAIL gapped[%0d] got %h exp %h", i, mon3_q[i], exp3_q[i]);
      end
    end
    for (int j = 0; j < 8; j++) begin
      tests++;
      if ((j < mon3_q.size() ? mon3_q[j].re : 'x) !== DW'(lit_re[j])) begin
        fails++; $display("FAIL gapped_re[%0d] got %0d exp %0d", j, j < mon3_q.size() ? mon3_q[j].re : 'x, lit_re[j]);
      end
    end
    mon3_q.delete(); exp3_q.delete();
  endtask

  task automatic test_resync();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, i == 0, pick(), pick());
    send_ramp(100, 200, 1'b1, 1'b0);
    idle(1'b0, 12);
    tests++;
    if (if3.frame_err_o !== 1'b1 || err_exp[0] !== 1'b1) begin
      fails++; $display("FAIL resync_err got %b exp 1", if3.frame_err_o);
    end
    tests++;
    if (mon3_q.size() !== exp3_q.size() || exp3_q.size() != 8) begin
      fails++; $display("FAIL resync_count got %0d exp 8", mon3_q.size());
    end
    for (int i = 0; i < exp3_q.size() && i < mon3_q.size(); i++) begin
      tests++;
      if (mon3_q[i] !== exp3_q[i]) begin
        fails++; $display("FAIL resync[%0d] got %h exp %h", i, mon3_q[i], exp3_q[i]);
      end
    end
    for (int j = 0; j < 8; j++) begin
      tests++;
      if ((j < mon3_q.size() ? mon3_q[j].re : 'x) !== DW'(100 + lit_re[j])) begin
        fails++; $display("FAIL resync_re[%0d] got %0d exp %0d", j, j < mon3_q.size() ? mon3_q[j].re : 'x, 100 + lit_re[j]);
      end
    end
    mon3_q.delete(); exp3_q.delete();
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    send_ramp(0, 10, 1'b0, 1'b0);
    for (int k = 0; k < 20 && !found; k++) begin
      idle(1'b0, 1);
      if (if3.valid_o === 1'b1 && if3.index_o === 3'd3) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL reset_mid_bin3 got none exp bin 3 within 20 cycles");
    end
    rst3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    tests++;
    if ({if3.valid_o, if3.last_o, if3.frame_err_o, if3.z_re_o, if3.z_im_o, if3.index_o} !== '0) begin
      fails++; $display("FAIL reset_mid_outputs got v%b l%b e%b %h/%h/%0d exp all 0",
                        if3.valid_o, if3.last_o, if3.frame_err_o, if3.z_re_o, if3.z_im_o, if3.index_o);
    end
    tests++;
    if (mon3_q.size() !== 4) begin
      fails++; $display("FAIL reset_mid_count got %0d exp 4", mon3_q.size());
    end
    for (int i = 0; i < 4 && i < mon3_q.size() && i < exp3_q.size(); i++) begin
      tests++;
      if (mon3_q[i] !== exp3_q[i]) begin
        fails++; $display("FAIL reset_mid[%0d] got %h exp %h", i, mon3_q[i], exp3_q[i]);
      end
    end
    model_reset(1'b0);
  endtask

  task automatic test_full_size();
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 1024; i++) drive(1'b1, 1'b1, (f == 0) && (i == 0), pick(), pick());
    idle(1'b1, 1030);
    tests++;
    if (mon10_q.size() !== exp10_q.size() || exp10_q.size() != 4096) begin
      fails++; $display("FAIL full_count got %0d exp 4096", mon10_q.size());
    end
    for (int i = 0; i < exp10_q.size() && i < mon10_q.size(); i++) begin
      tests++;
      if (mon10_q[i] !== exp10_q[i]) begin
        fails++; $display("FAIL full[%0d] got %h exp %h", i, mon10_q[i], exp10_q[i]);
      end
    end
    tests++;
    if (if10.frame_err_o !== 1'b0) begin
      fails++; $display("FAIL full_err got %b exp 0", if10.frame_err_o);
    end
    mon10_q.delete(); exp10_q.delete();
  endtask

  initial begin
    test_reset();
    test_prestart();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_resync();
    test_reset_mid();
    test_prestart();
    test_basic();
    test_full_size();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
